sram_seg_flag_ctrl: RTL and testbench
=====================================

// Module: sram_seg_flag_ctrl
// PURPOSE
//   Upstream producer of the 6-bit SRAM segment-full flag vector read by the HPS through its input PIO.
//   Takes the deserialised LVDS word stream and writes it into NUM_SEG equal SRAM segments used as a ring.
//   Raises one flag bit per filled segment and holds it until the HPS acknowledges that segment via flag_clr.
//   A stream arriving while the next segment is still unacknowledged is dropped and counted.
// PARAMETERS
//   DATA_W     32   SRAM/stream word width
//   NUM_SEG    6    number of ring segments = flag vector width (2..8)
//   SEG_IDX_W  3    segment index width, ceil(log2(NUM_SEG))
//   SEG_AW     10   word address width inside one segment; segment depth = 2**SEG_AW words
// PORTS
//   clk          in   1                   system clock, all logic rising-edge
//   reset        in   1                   synchronous, active-high reset
//   enable       in   1                   capture enable from HPS control PIO
//   in_valid     in   1                   stream word strobe (no backpressure)
//   in_data      in   DATA_W              stream word
//   flag_clr     in   NUM_SEG             per-segment acknowledge pulses from HPS
//   sram_we      out  1                   SRAM write strobe
//   sram_addr    out  SEG_IDX_W+SEG_AW    {segment index, word index}
//   sram_wdata   out  DATA_W              SRAM write data
//   flag_out     out  NUM_SEG             segment-full flags, to the input PIO in_port
//   cur_seg      out  SEG_IDX_W           segment currently being filled
//   dropping     out  1                   high while in DROP state
//   overflow_cnt out  16                  dropped-word counter, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (synchronous, active-high, on the clk edge): state=IDLE, cur_seg=0, word index=0.
//     All outputs are 0, including flag_out, overflow_cnt, sram_*, and dropping.
//   FSM states: IDLE, FILL, DROP.
//     IDLE -> FILL when enable=1. Fill resumes at word 0 of cur_seg.
//     Any state -> IDLE when enable=0; the partially filled segment is abandoned.
//       word index returns to 0. cur_seg, flags and overflow_cnt are kept.
//   FILL: each in_valid word is registered onto sram_we/sram_addr/sram_wdata.
//     Write latency: word accepted at cycle N -> sram_we=1 at N+1. sram_we is low otherwise.
//     sram_addr = {cur_seg, word_idx}; word_idx then increments.
//   Segment complete: the write of word 2**SEG_AW-1 is issued at cycle M.
//     flag_out[cur_seg] rises at M+1, so the data is committed before the flag is visible.
//     cur_seg advances at the same edge: NUM_SEG-1 wraps to 0. word_idx wraps to 0.
//   Next-segment check at advance:
//     if flag_out[next] is set and not cleared in that same cycle -> DROP, else stay in FILL.
//   DROP: no SRAM writes. Each in_valid increments overflow_cnt, saturating.
//     DROP -> FILL on the cycle after flag_out[cur_seg] is cleared.
//     Writing resumes at word 0 with the next in_valid.
//   flag_clr[i]=1 clears flag_out[i] on the next edge. Clearing an already-clear bit has no effect.
//   Same-cycle set and clear of one bit: set wins, flag stays 1.
//   flag_out is a plain register with no combinational path from any input.
//   enable=0 during a pending last-word write: that write still completes.
//     The flag is not set and the segment is not advanced.
//   overflow_cnt is cleared only by reset.
// TESTING (SEG_AW=4, i.e. 16-word segments, NUM_SEG=6)
//   1. Reset, then enable=1 and 16 valid words 0..15.
//      -> sram_addr 0x00..0x0F with wdata 0..15, each 1 cycle late.
//      -> flag_out=6'b000001 one cycle after the last write. cur_seg=1.
//   2. 96 words with no acks.
//      -> flag_out=6'b111111, cur_seg=0, dropping=1.
//      -> next 5 words give overflow_cnt=5 and no sram_we.
//   3. From case 2, pulse flag_clr=6'b000001.
//      -> flag_out=6'b111110, dropping=0 next cycle.
//      -> next word written at sram_addr 0x00.
//   4. At the advance into a flagged segment, pulse flag_clr for that segment in the same cycle.
//      -> no DROP; writes continue at {next,0}.
//   5. enable=0 after 7 words into segment 2, then enable=1.
//      -> flag_out unchanged; next write at sram_addr {2,0}=0x20.
//   6. Assert reset mid-segment while dropping with overflow_cnt=3.
//      -> all outputs 0 on the next edge, then a normal restart at addr 0x00.
//   7. Force overflow_cnt to 16'hFFFF while dropping. -> it stays 16'hFFFF.

Source files
------------

// File: rtl/sram_seg_flag_ctrl.sv
// sram_seg_flag_ctrl
// Writes the incoming stream into NUM_SEG equal SRAM segments that are used as a ring.
// One flag bit is raised per filled segment and held until the HPS acknowledges it.
// A stream arriving while the next segment is still unacknowledged is dropped and counted.
module sram_seg_flag_ctrl #(
    parameter int DATA_W    = 32,
    parameter int NUM_SEG   = 6,
    parameter int SEG_IDX_W = 3,
    parameter int SEG_AW    = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [NUM_SEG-1:0]          flag_clr,
    output logic                        sram_we,
    output logic [SEG_IDX_W+SEG_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]           sram_wdata,
    output logic [NUM_SEG-1:0]          flag_out,
    output logic [SEG_IDX_W-1:0]        cur_seg,
    output logic                        dropping,
    output logic [15:0]                 overflow_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                        state_r;
    logic [SEG_AW-1:0]             word_idx_r;
    // Set when the last word of the segment has just been handed to the SRAM;
    // the flag and segment advance happen one edge later, after the write lands.
    logic                          last_pend_r;
    logic                          sram_we_r;
    logic [SEG_IDX_W+SEG_AW-1:0]   sram_addr_r;
    logic [DATA_W-1:0]             sram_wdata_r;
    logic [NUM_SEG-1:0]            flag_r;
    logic [SEG_IDX_W-1:0]          cur_seg_r;
    logic                          dropping_r;
    logic [15:0]                   overflow_cnt_r;

    logic [SEG_IDX_W-1:0]          nxt_seg_s;
    logic [SEG_IDX_W-1:0]          seg_eff_s;
    logic                          next_busy_s;
    logic                          seg_last_s;
    logic [NUM_SEG-1:0]            flag_set_s;
    logic [15:0]                   cnt_inc_s;

    // Segment advance, next-segment occupancy, flag set request and saturating count.
    always_comb begin
        nxt_seg_s   = {SEG_IDX_W{1'b0}};
        flag_set_s  = {NUM_SEG{1'b0}};
        if (cur_seg_r == SEG_IDX_W'(NUM_SEG - 1)) begin
            nxt_seg_s = {SEG_IDX_W{1'b0}};
        end else begin
            nxt_seg_s = cur_seg_r + SEG_IDX_W'(1);
        end
        // An acknowledge arriving in the advance cycle frees the segment in time.
        next_busy_s = flag_r[nxt_seg_s] & ~flag_clr[nxt_seg_s];
        // Words accepted in the advance cycle already belong to the next segment.
        if (last_pend_r) begin
            seg_eff_s = nxt_seg_s;
        end else begin
            seg_eff_s = cur_seg_r;
        end
        seg_last_s = (word_idx_r == {SEG_AW{1'b1}});
        if ((state_r == ST_FILL) && enable && last_pend_r) begin
            flag_set_s[cur_seg_r] = 1'b1;
        end else begin
            flag_set_s = {NUM_SEG{1'b0}};
        end
        if (overflow_cnt_r == 16'hFFFF) begin
            cnt_inc_s = overflow_cnt_r;
        end else begin
            cnt_inc_s = overflow_cnt_r + 16'd1;
        end
    end

    // Capture FSM with registered SRAM port, flags and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            word_idx_r     <= {SEG_AW{1'b0}};
            last_pend_r    <= 1'b0;
            sram_we_r      <= 1'b0;
            sram_addr_r    <= {(SEG_IDX_W + SEG_AW){1'b0}};
            sram_wdata_r   <= {DATA_W{1'b0}};
            flag_r         <= {NUM_SEG{1'b0}};
            cur_seg_r      <= {SEG_IDX_W{1'b0}};
            dropping_r     <= 1'b0;
            overflow_cnt_r <= 16'd0;
        end else begin
            sram_we_r <= 1'b0;
            // Set wins over a same-cycle clear of the same bit.
            flag_r    <= (flag_r & ~flag_clr) | flag_set_s;
            case (state_r)
                ST_IDLE: begin
                    word_idx_r  <= {SEG_AW{1'b0}};
                    last_pend_r <= 1'b0;
                    dropping_r  <= 1'b0;
                    if (enable) begin
                        state_r <= ST_FILL;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (!enable) begin
                        // Partial segment abandoned; a pending last write still lands.
                        state_r     <= ST_IDLE;
                        word_idx_r  <= {SEG_AW{1'b0}};
                        last_pend_r <= 1'b0;
                        dropping_r  <= 1'b0;
                    end else if (last_pend_r && next_busy_s) begin
                        cur_seg_r   <= nxt_seg_s;
                        word_idx_r  <= {SEG_AW{1'b0}};
                        last_pend_r <= 1'b0;
                        state_r     <= ST_DROP;
                        dropping_r  <= 1'b1;
                        if (in_valid) begin
                            overflow_cnt_r <= cnt_inc_s;
                        end else begin
                            overflow_cnt_r <= overflow_cnt_r;
                        end
                    end else begin
                        cur_seg_r <= seg_eff_s;
                        if (in_valid) begin
                            sram_we_r    <= 1'b1;
                            sram_addr_r  <= {seg_eff_s, word_idx_r};
                            sram_wdata_r <= in_data;
                            word_idx_r   <= word_idx_r + SEG_AW'(1);
                            last_pend_r  <= seg_last_s;
                        end else begin
                            last_pend_r  <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (in_valid) begin
                        overflow_cnt_r <= cnt_inc_s;
                    end else begin
                        overflow_cnt_r <= overflow_cnt_r;
                    end
                    word_idx_r  <= {SEG_AW{1'b0}};
                    last_pend_r <= 1'b0;
                    if (!enable) begin
                        state_r    <= ST_IDLE;
                        dropping_r <= 1'b0;
                    end else if (flag_clr[cur_seg_r] || !flag_r[cur_seg_r]) begin
                        state_r    <= ST_FILL;
                        dropping_r <= 1'b0;
                    end else begin
                        state_r    <= ST_DROP;
                        dropping_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    word_idx_r  <= {SEG_AW{1'b0}};
                    last_pend_r <= 1'b0;
                    dropping_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_we      = sram_we_r;
    assign sram_addr    = sram_addr_r;
    assign sram_wdata   = sram_wdata_r;
    assign flag_out     = flag_r;
    assign cur_seg      = cur_seg_r;
    assign dropping     = dropping_r;
    assign overflow_cnt = overflow_cnt_r;

endmodule

// File: tb/tb_sram_seg_flag_ctrl.sv
// Directed bench for sram_seg_flag_ctrl with 16-word segments and six segments.
module tb_sram_seg_flag_ctrl;

    localparam int DATA_W    = 32;
    localparam int NUM_SEG   = 6;
    localparam int SEG_IDX_W = 3;
    localparam int SEG_AW    = 4;

    logic                        clk;
    logic                        reset;
    logic                        enable;
    logic                        in_valid;
    logic [DATA_W-1:0]           in_data;
    logic [NUM_SEG-1:0]          flag_clr;
    logic                        sram_we;
    logic [SEG_IDX_W+SEG_AW-1:0] sram_addr;
    logic [DATA_W-1:0]           sram_wdata;
    logic [NUM_SEG-1:0]          flag_out;
    logic [SEG_IDX_W-1:0]        cur_seg;
    logic                        dropping;
    logic [15:0]                 overflow_cnt;

    int total;
    int bad;

    sram_seg_flag_ctrl #(
        .DATA_W(DATA_W), .NUM_SEG(NUM_SEG), .SEG_IDX_W(SEG_IDX_W), .SEG_AW(SEG_AW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .flag_clr(flag_clr), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .flag_out(flag_out),
        .cur_seg(cur_seg), .dropping(dropping), .overflow_cnt(overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // compare one observed value with its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stream n consecutive words, checking each registered write
    task automatic send_words(input int n, input int data_base, input int addr_base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(data_base + i);
            tick();
            chk("wr_we",   32'(sram_we),    32'd1);
            chk("wr_addr", 32'(sram_addr),  32'(addr_base + i));
            chk("wr_data", 32'(sram_wdata), 32'(data_base + i));
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},   32'(sram_we),      32'd0);
        chk({tag, "_addr"}, 32'(sram_addr),    32'd0);
        chk({tag, "_wd"},   32'(sram_wdata),   32'd0);
        chk({tag, "_flag"}, 32'(flag_out),     32'd0);
        chk({tag, "_seg"},  32'(cur_seg),      32'd0);
        chk({tag, "_drop"}, 32'(dropping),     32'd0);
        chk({tag, "_ovf"},  32'(overflow_cnt), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        flag_clr = 6'b000000;

        // 1: one segment, flag one cycle after last write
        do_reset();
        chk_all_zero("rst");
        enable = 1'b1;
        tick();
        send_words(16, 0, 0);
        chk("t1_flag_early", 32'(flag_out), 32'h00);
        tick();
        chk("t1_flag",  32'(flag_out), 32'h01);
        chk("t1_seg",   32'(cur_seg),  32'd1);
        chk("t1_we_lo", 32'(sram_we),  32'd0);

        // 2: fill the whole ring without acks, then drop
        do_reset();
        enable = 1'b1;
        tick();
        send_words(96, 0, 0);
        tick();
        chk("t2_flag", 32'(flag_out), 32'h3F);
        chk("t2_seg",  32'(cur_seg),  32'd0);
        chk("t2_drop", 32'(dropping), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            tick();
            chk("t2_no_we", 32'(sram_we), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("t2_ovf", 32'(overflow_cnt), 32'd5);

        // 3: ack segment 0 leaves drop
        flag_clr = 6'b000001;
        tick();
        flag_clr = 6'b000000;
        chk("t3_flag", 32'(flag_out), 32'h3E);
        chk("t3_drop", 32'(dropping), 32'd0);
        send_words(1, 32'hAA, 32'h00);

        // 4: ack the next segment in the advance cycle
        send_words(15, 32'h101, 32'h01);
        flag_clr = 6'b000010;
        in_valid = 1'b1;
        in_data  = 32'hBB;
        tick();
        flag_clr = 6'b000000;
        in_valid = 1'b0;
        chk("t4_flag", 32'(flag_out),   32'h3D);
        chk("t4_seg",  32'(cur_seg),    32'd1);
        chk("t4_drop", 32'(dropping),   32'd0);
        chk("t4_we",   32'(sram_we),    32'd1);
        chk("t4_addr", 32'(sram_addr),  32'h10);
        chk("t4_data", 32'(sram_wdata), 32'hBB);

        // 5: abandon segment 2 after 7 words
        flag_clr = 6'b000100;
        tick();
        flag_clr = 6'b000000;
        chk("t5_clr", 32'(flag_out), 32'h39);
        send_words(15, 32'h200, 32'h11);
        tick();
        chk("t5_adv_flag", 32'(flag_out), 32'h3B);
        chk("t5_adv_seg",  32'(cur_seg),  32'd2);
        send_words(7, 32'h300, 32'h20);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk("t5_flag", 32'(flag_out), 32'h3B);
        chk("t5_seg",  32'(cur_seg),  32'd2);
        send_words(1, 32'h400, 32'h20);

        // 6: reset while dropping
        do_reset();
        enable = 1'b1;
        tick();
        send_words(96, 32'h1000, 0);
        tick();
        send_words(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t6_ovf",  32'(overflow_cnt), 32'd3);
        chk("t6_drop", 32'(dropping),     32'd1);
        in_valid = 1'b1;
        do_reset();
        in_valid = 1'b0;
        chk_all_zero("t6_rst");
        tick();
        send_words(1, 32'h55, 32'h00);

        // enable drop during the pending last write: write lands, no flag
        send_words(15, 32'h60, 32'h01);
        enable = 1'b0;
        tick();
        chk("pend_flag", 32'(flag_out), 32'h00);
        chk("pend_seg",  32'(cur_seg),  32'd0);
        chk("pend_we",   32'(sram_we),  32'd0);

        // 7: counter saturation
        do_reset();
        enable = 1'b1;
        tick();
        send_words(96, 0, 0);
        tick();
        chk("t7_drop", 32'(dropping), 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk("t7_fffe", 32'(overflow_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        chk("t7_sat",  32'(overflow_cnt), 32'hFFFF);
        chk("t7_flag", 32'(flag_out),     32'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
